// File: rtl/operand_skew_feeder.sv
// Transmit side of the PE operand interface: frames a tile of operand vectors and
// drives them into the systolic array edge with a per-lane diagonal skew.
module operand_skew_feeder #(
  parameter int unsigned OPERAND_WIDTH = 8,
  parameter int unsigned ROWS          = 4,
  parameter int unsigned K_DEPTH       = 4
) (
  input  logic                          clk_i,
  input  logic                          reset,
  input  logic                          start_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic [ROWS*OPERAND_WIDTH-1:0] in_data_i,
  output logic [ROWS*OPERAND_WIDTH-1:0] a_o,
  output logic                          a_valid_o,
  output logic                          busy_o,
  output logic                          tile_done_o
);

  localparam int unsigned KCntW = $clog2(K_DEPTH + 1);
  localparam int unsigned FCntW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [KCntW-1:0] KLast = KCntW'(K_DEPTH - 1);
  localparam logic [FCntW-1:0] FLast = FCntW'((ROWS > 1) ? ROWS - 2 : 0);

  typedef enum logic [1:0] {StIdle, StStream, StFlush, StDone} state_e;

  state_e                          state_q, state_d;
  logic [KCntW-1:0]                k_cnt_q, k_cnt_d;
  logic [FCntW-1:0]                flush_cnt_q, flush_cnt_d;
  logic                            a_valid_q;
  logic                            tile_done_q;
  logic                            accept;
  logic                            advance;
  logic [ROWS*OPERAND_WIDTH-1:0]   lane_in;

  always_comb begin
    state_d     = state_q;
    k_cnt_d     = k_cnt_q;
    flush_cnt_d = flush_cnt_q;
    in_ready_o  = (state_q == StStream);
    accept      = in_ready_o & in_valid_i;
    // Flush cycles advance the pipeline with zeros so the last vector drains out.
    advance     = accept | (state_q == StFlush);
    lane_in     = accept ? in_data_i : '0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StStream;
          k_cnt_d = '0;
        end
      end
      StStream: begin
        if (accept) begin
          k_cnt_d = k_cnt_q + 1'b1;
          if (k_cnt_q == KLast) begin
            flush_cnt_d = '0;
            state_d     = (ROWS > 1) ? StFlush : StDone;
          end
        end
      end
      StFlush: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset) begin
      state_q     <= StIdle;
      k_cnt_q     <= '0;
      flush_cnt_q <= '0;
      a_valid_q   <= 1'b0;
      tile_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_cnt_q     <= k_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      a_valid_q   <= advance;
      tile_done_q <= (state_q == StDone);
    end
  end

  // Lane r is a chain of r+1 stages, so it lags lane 0 by r array steps.
  for (genvar r = 0; r < int'(ROWS); r++) begin : g_lane
    logic [OPERAND_WIDTH-1:0] stage_q [r+1];

    always_ff @(posedge clk_i) begin
      if (!reset) begin
        for (int s = 0; s <= r; s++) begin
          stage_q[s] <= '0;
        end
      end else if (advance) begin
        stage_q[0] <= lane_in[r*OPERAND_WIDTH +: OPERAND_WIDTH];
        for (int s = 1; s <= r; s++) begin
          stage_q[s] <= stage_q[s-1];
        end
      end
    end

    assign a_o[r*OPERAND_WIDTH +: OPERAND_WIDTH] = stage_q[r];
  end

  assign a_valid_o   = a_valid_q;
  assign busy_o      = (state_q != StIdle);
  assign tile_done_o = tile_done_q;

endmodule
